// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-high segment
// patterns ({g,f,e,d,c,b,a}) and the per-slot scan state encoding.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, active-high segments.
// Non-decimal codes show a dash so a corrupted counter is visible on the board.
module bcd_to_7seg (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    import seven_seg_pkg::*;

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode display driver: snapshots BCD digits once per
// frame, decodes them and scans one digit per slot with a dark gap at slot start.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYC       = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    i_clki,
    input  logic                    i_reset_n,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_digits_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_blank_lz,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_tick
);
    import seven_seg_pkg::*;

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0] DEAD_LAST = PRESC_W'(DEAD_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    scan_state_t             r_state;
    scan_state_t             w_state_next;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic [NUM_DIGITS-1:0]   r_dp_pending;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [NUM_DIGITS-1:0]   r_dp_active;
    logic                    r_blank_lz;

    logic                    w_wrap;
    logic                    w_frame_start;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_digit;
    logic                    w_sel_dp;
    logic                    w_sel_blank;
    logic [6:0]              w_dec_seg;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [6:0]              w_seg_next;
    logic                    w_dp_next;

    assign w_wrap        = (r_presc == PRESC_MAX);
    assign w_frame_start = w_wrap && (r_idx == IDX_MAX);

    always_ff @(posedge i_clki or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge i_clki or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= DEAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load coinciding with the frame boundary bypasses the pending copy so the newest value wins.
    always_ff @(posedge i_clki or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending    <= '0;
            r_dp_pending <= '0;
            r_active     <= '0;
            r_dp_active  <= '0;
            r_blank_lz   <= 1'b0;
            o_frame_tick <= 1'b0;
        end else begin
            if (i_load) begin
                r_pending    <= i_digits_in;
                r_dp_pending <= i_dp_in;
            end
            if (w_frame_start) begin
                r_active    <= i_load ? i_digits_in : r_pending;
                r_dp_active <= i_load ? i_dp_in : r_dp_pending;
                r_blank_lz  <= i_blank_lz;
            end
            o_frame_tick <= w_frame_start;
        end
    end

    // Walk from the most significant digit down; a digit blanks only while every digit above is zero.
    always_comb begin : lz_mask
        logic v_zero;
        v_zero  = 1'b1;
        w_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_zero     = v_zero & (r_active[4*k +: 4] == 4'd0);
            w_blank[k] = r_blank_lz & v_zero & (k != 0);
        end
    end

    always_comb begin
        w_digit     = '0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit     = r_active[4*k +: 4];
                w_sel_dp    = r_dp_active[k];
                w_sel_blank = w_blank[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    bcd_to_7seg u_decoder (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    always_comb begin
        w_state_next = r_state;
        w_an_next    = '0;
        w_seg_next   = SEG_OFF;
        w_dp_next    = 1'b0;
        case (r_state)
            DEAD: begin
                if (r_presc == DEAD_LAST) begin
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (w_wrap) begin
                    w_state_next = DEAD;
                end
                w_an_next  = w_onehot;
                w_seg_next = w_sel_blank ? SEG_OFF : w_dec_seg;
                w_dp_next  = w_sel_dp;
            end
        endcase
    end

    // Pin polarity is applied only here; everything upstream is active-high.
    always_ff @(posedge i_clki or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_an  <= {NUM_DIGITS{AN_INV}};
            o_seg <= {7{SEG_INV}};
            o_dp  <= SEG_INV;
        end else begin
            o_an  <= w_an_next ^ {NUM_DIGITS{AN_INV}};
            o_seg <= w_seg_next ^ {7{SEG_INV}};
            o_dp  <= w_dp_next ^ SEG_INV;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: whole frames are checked cycle by
// cycle against hand-derived segment tables, with loads placed inside frames.
module tb_seven_seg_scan_driver;

    logic        i_clki;
    logic        i_reset_n;
    logic        i_load;
    logic [15:0] i_digits_in;
    logic [3:0]  i_dp_in;
    logic        i_blank_lz;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_an;
    logic        o_frame_tick;

    int assertCount = 0;
    int failCount   = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .DEAD_CYC       (1),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .i_clki       (i_clki),
        .i_reset_n    (i_reset_n),
        .i_load       (i_load),
        .i_digits_in  (i_digits_in),
        .i_dp_in      (i_dp_in),
        .i_blank_lz   (i_blank_lz),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_an         (o_an),
        .o_frame_tick (o_frame_tick)
    );

    initial i_clki = 1'b0;
    always #5 i_clki = ~i_clki;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Active-high reference patterns, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] refSeg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic load, input logic [15:0] digits, input logic [3:0] dp);
        i_load = load;
        if (load) begin
            i_digits_in = digits;
            i_dp_in     = dp;
        end
    endtask

    task automatic tick;
        @(negedge i_clki);
    endtask

    // Checks the 16 edges of one frame; edge 16 is the next frame boundary.
    task automatic checkFrame(input logic [15:0] expDig, input logic [3:0] expDp, input logic expLz,
                              input int ldJ1, input logic [15:0] ldD1, input logic [3:0] ldP1,
                              input int ldJ2, input logic [15:0] ldD2, input logic [3:0] ldP2,
                              input logic nextLz);
        int          slot;
        logic        drive;
        logic        blank;
        logic [3:0]  oneHot;
        logic [3:0]  expAn;
        logic [6:0]  expSeg;
        logic        expDpPin;
        for (int j = 1; j <= 16; j++) begin
            if (j == ldJ1) applyStimulus(1'b1, ldD1, ldP1);
            else if (j == ldJ2) applyStimulus(1'b1, ldD2, ldP2);
            else applyStimulus(1'b0, 16'h0, 4'h0);
            if (j == 2) i_blank_lz = nextLz;
            tick;
            slot  = (j - 1) / 4;
            drive = ((j - 1) % 4) != 0;
            blank = expLz && (slot != 0);
            for (int k = slot; k < 4; k++) begin
                if (expDig[4*k +: 4] != 4'd0) blank = 1'b0;
            end
            oneHot   = 4'b0001 << slot;
            expAn    = drive ? ~oneHot : 4'hF;
            expSeg   = (drive && !blank) ? ~refSeg(expDig[4*slot +: 4]) : 7'h7F;
            expDpPin = !(drive && expDp[slot]);
            checkOutput($sformatf("an %h e%0d", expDig, j), 32'(o_an), 32'(expAn));
            checkOutput($sformatf("seg %h e%0d", expDig, j), 32'(o_seg), 32'(expSeg));
            checkOutput($sformatf("dp %h e%0d", expDig, j), 32'(o_dp), 32'(expDpPin));
            checkOutput($sformatf("tick %h e%0d", expDig, j), 32'(o_frame_tick), 32'(j == 16));
        end
        applyStimulus(1'b0, 16'h0, 4'h0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " an"},   32'(o_an),         32'hF);
        checkOutput({tag, " seg"},  32'(o_seg),        32'h7F);
        checkOutput({tag, " dp"},   32'(o_dp),         32'h1);
        checkOutput({tag, " tick"}, 32'(o_frame_tick), 32'h0);
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_load      = 1'b0;
        i_digits_in = 16'h0;
        i_dp_in     = 4'h0;
        i_blank_lz  = 1'b0;
        repeat (3) tick;
        checkResetOutputs("por");
        i_reset_n = 1'b1;

        // Post-reset frame shows zeros; 1234 is queued for the next frame.
        checkFrame(16'h0000, 4'h0, 1'b0, 8, 16'h1234, 4'h0, 0, 16'h0, 4'h0, 1'b0);
        // Mid-frame loads must not tear the frame being shown.
        checkFrame(16'h1234, 4'h0, 1'b0, 10, 16'h0009, 4'h0, 14, 16'h0010, 4'h0, 1'b0);
        // Load exactly on the boundary edge goes straight to the display.
        checkFrame(16'h0010, 4'h0, 1'b0, 16, 16'h5678, 4'h0, 0, 16'h0, 4'h0, 1'b0);
        checkFrame(16'h5678, 4'h0, 1'b0, 3, 16'hA0F3, 4'b0100, 0, 16'h0, 4'h0, 1'b0);
        checkFrame(16'hA0F3, 4'b0100, 1'b0, 5, 16'h0090, 4'h0, 0, 16'h0, 4'h0, 1'b1);
        checkFrame(16'h0090, 4'h0, 1'b1, 5, 16'h0000, 4'b1010, 0, 16'h0, 4'h0, 1'b1);
        checkFrame(16'h0000, 4'b1010, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b1);

        // Asynchronous reset in the middle of a slot-1 drive phase.
        repeat (6) tick;
        checkOutput("pre-reset an", 32'(o_an), 32'hD);
        checkOutput("pre-reset dp", 32'(o_dp), 32'h0);
        i_reset_n  = 1'b0;
        i_blank_lz = 1'b0;
        #1;
        checkResetOutputs("async");
        repeat (2) tick;
        checkResetOutputs("held");
        i_reset_n = 1'b1;
        checkFrame(16'h0000, 4'h0, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
